// File: rtl/insn_chk_stage_if.sv
// Bundles the fetch-side inputs and registered check results of insn_chk_stage.
// The stage drives the results; the producer or testbench drives the inputs.
interface insn_chk_stage_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      instr_i;
   logic [31:0]      pc_i;
   logic             vld_i;
   logic             stall_i;
   logic             flush_i;
   logic             clr_first_i;
   logic [31:0]      instr_o;
   logic [31:0]      pc_o;
   logic             vld_o;
   logic             insn_vld_o;
   logic             illegal_o;
   logic [CNT_W-1:0] ill_cnt_o;
   logic             first_vld_o;
   logic [31:0]      first_pc_o;
   logic [31:0]      first_instr_o;

   modport master (
      output instr_i, pc_i, vld_i, stall_i, flush_i, clr_first_i,
      input  instr_o, pc_o, vld_o, insn_vld_o, illegal_o, ill_cnt_o,
             first_vld_o, first_pc_o, first_instr_o
   );

   modport slave (
      input  instr_i, pc_i, vld_i, stall_i, flush_i, clr_first_i,
      output instr_o, pc_o, vld_o, insn_vld_o, illegal_o, ill_cnt_o,
             first_vld_o, first_pc_o, first_instr_o
   );
endinterface

// File: rtl/insn_chk_stage.sv
// RV32I(+M/Zicsr/SYSTEM) legality check stage: registers instr/pc/valid/legal,
// counts illegal instructions (saturating) and captures the first illegal one.
module insn_chk_stage #(
   parameter bit EN_M      = 1'b1,
   parameter bit EN_ZICSR  = 1'b1,
   parameter bit EN_SYSTEM = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   insn_chk_stage_if.slave bus
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0]  F7_BASE = 7'b0000000;
   localparam logic [6:0]  F7_ALT  = 7'b0100000;
   localparam logic [6:0]  F7_MULDIV = 7'b0000001;
   localparam logic [24:0] SYS_ECALL  = 25'h0000000;
   localparam logic [24:0] SYS_EBREAK = 25'h0002000;

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_legal;
   logic       w_acc;
   logic       w_ill_ev;

   logic [31:0]      r_instr;
   logic [31:0]      r_pc;
   logic             r_vld;
   logic             r_insn_vld;
   logic [CNT_W-1:0] r_cnt;
   logic             r_first_vld;
   logic [31:0]      r_first_pc;
   logic [31:0]      r_first_instr;

   assign w_opc = bus.instr_i[6:0];
   assign w_f3  = bus.instr_i[14:12];
   assign w_f7  = bus.instr_i[31:25];

   always_comb begin
      w_legal = 1'b0;
      case (w_opc)
         OPC_OP: begin
            if (w_f7 == F7_BASE)        w_legal = 1'b1;
            else if (w_f7 == F7_ALT)    w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            else if (w_f7 == F7_MULDIV) w_legal = EN_M;
            else                        w_legal = 1'b0;
         end
         OPC_OPIMM: begin
            // Only the shift-immediate forms carry a funct7 qualifier.
            if (w_f3 == 3'b001)      w_legal = (w_f7 == F7_BASE);
            else if (w_f3 == 3'b101) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            else                     w_legal = 1'b1;
         end
         OPC_LOAD:   w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
         OPC_STORE:  w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
         OPC_BRANCH: w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
         OPC_JALR:   w_legal = (w_f3 == 3'b000);
         OPC_JAL, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
         OPC_MISC:   w_legal = EN_SYSTEM && (w_f3 == 3'b000);
         OPC_SYSTEM: begin
            if (w_f3 == 3'b000)
               w_legal = EN_SYSTEM && ((bus.instr_i[31:7] == SYS_ECALL) ||
                                       (bus.instr_i[31:7] == SYS_EBREAK));
            else if (w_f3 == 3'b100)
               w_legal = 1'b0;
            else
               w_legal = EN_ZICSR;
         end
         default:    w_legal = 1'b0;
      endcase
   end

   assign w_acc    = bus.vld_i & ~bus.stall_i & ~bus.flush_i;
   assign w_ill_ev = w_acc & ~w_legal;

   // Flush only kills valid; payload holds so the register need not toggle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_instr    <= '0;
         r_pc       <= '0;
         r_vld      <= 1'b0;
         r_insn_vld <= 1'b0;
      end else if (bus.flush_i) begin
         r_vld      <= 1'b0;
      end else if (!bus.stall_i) begin
         r_instr    <= bus.instr_i;
         r_pc       <= bus.pc_i;
         r_vld      <= bus.vld_i;
         r_insn_vld <= w_legal;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (w_ill_ev && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // A clear in the same cycle as an illegal event re-arms and captures at once.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_first_vld   <= 1'b0;
         r_first_pc    <= '0;
         r_first_instr <= '0;
      end else if (w_ill_ev && (!r_first_vld || bus.clr_first_i)) begin
         r_first_vld   <= 1'b1;
         r_first_pc    <= bus.pc_i;
         r_first_instr <= bus.instr_i;
      end else if (bus.clr_first_i) begin
         r_first_vld   <= 1'b0;
      end
   end

   assign bus.instr_o       = r_instr;
   assign bus.pc_o          = r_pc;
   assign bus.vld_o         = r_vld;
   assign bus.insn_vld_o    = r_insn_vld;
   assign bus.illegal_o     = r_vld & ~r_insn_vld;
   assign bus.ill_cnt_o     = r_cnt;
   assign bus.first_vld_o   = r_first_vld;
   assign bus.first_pc_o    = r_first_pc;
   assign bus.first_instr_o = r_first_instr;
endmodule
